note_sequencer: RTL and testbench
=================================

NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter DEPTH, default 16, number of pattern entries.
REQ-002 Parameter AW, default 4, pattern address width; DEPTH SHALL equal 2**AW.
REQ-003 note_clk  in  1  note clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 wr_en  in  1  pattern write strobe.
REQ-006 wr_addr  in  AW  pattern write address.
REQ-007 wr_data  in  16  entry {rest[15], length[14:12], decay[11:10], attack[9:8], pitch[7:0]}.
REQ-008 start  in  1  begin playback at address 0; level-sampled each cycle.
REQ-009 stop  in  1  abort playback; level-sampled each cycle.
REQ-010 last_addr  in  AW  final step of pattern.
REQ-011 attack/decay/length  out  2/2/3  parameters of the current note, to the envelope stage.
REQ-012 pitch  out  8  pitch of the current note, to the waveform generator.
REQ-013 trig  out  1  one-cycle note start, drives the envelope stage's rst.
REQ-014 mute  out  1  high during a rest step or while idle.
REQ-015 playing  out  1  high in any state other than IDLE.
REQ-016 step_addr  out  AW  address of the current step.
REQ-017 done  out  1  one-cycle pulse when a non-looping pattern finishes.

Function
REQ-018 Storage SHALL be a DEPTH x 16 register array written synchronously when wr_en=1; a write SHALL NOT change the outputs of the note currently playing.
REQ-019 The FSM SHALL have three states: IDLE, TRIG, and HOLD.
REQ-020 IDLE: when start=1 and stop=0, the FSM SHALL set step_addr=0 and go to TRIG; otherwise it SHALL stay in IDLE.
REQ-021 TRIG (exactly one cycle): outputs SHALL be registered from entry[step_addr]; trig=1 when rest=0, trig=0 and mute=1 when rest=1; duration counter SHALL load 2**(length+1); the FSM SHALL go to HOLD.
REQ-022 HOLD: the counter SHALL decrement each cycle; at counter==0 the FSM SHALL advance.
REQ-023 The total step time SHALL be 2**(length+1)+2 cycles (length=0 gives 4, length=7 gives 258); the counter SHALL be 9 bits, with no overflow.
REQ-024 Advance: if step_addr!=last_addr, step_addr+1 and TRIG; if equal, see REQ-031/032.
REQ-025 trig SHALL be registered (no combinational path from inputs) and SHALL be high in TRIG cycles only.
REQ-026 stop=1 in any state SHALL force IDLE on the next edge, with trig=0 and mute=1; stop SHALL win over simultaneous start.
REQ-027 start while playing SHALL be ignored.
REQ-028 If last_addr changes mid-playback, the new value SHALL be used at the next advance; if step_addr>last_addr, playback SHALL continue incrementing and wrap from DEPTH-1 to 0.
REQ-029 In IDLE, attack/decay/length/pitch SHALL hold their last values.

Reset
REQ-030 rst SHALL clear the FSM to IDLE, step_addr/counter to 0, attack/decay/length/pitch to 0, trig/done/playing to 0, and mute to 1; pattern contents SHALL be undefined and need not be reset.

Configuration
REQ-031 With NOTE_SEQ_LOOP_EN defined, advance past last_addr SHALL set step_addr=0 and go to TRIG; done SHALL never pulse.
REQ-032 Without NOTE_SEQ_LOOP_EN, advance past last_addr SHALL go to IDLE with done=1 for one cycle, mute=1, and playing=0.

Structure
REQ-033 A shared package SHALL hold the entry field bit positions, the state encoding (IDLE=0, TRIG=1, HOLD=2), and the duration width constant 9.
REQ-034 One sub-module, note_pattern_ram (DEPTH x 16, 1 write port, 1 async read port), SHALL hold the storage; the FSM SHALL stay in note_sequencer.

Verification
REQ-035 Write entry0={0,3'd0,2'd1,2'd2,8'h40} and last_addr=0, then pulse start: trig at cycle 1, attack=2, decay=1, pitch=0x40, done 4 cycles after trig, then IDLE.
REQ-036 Three entries with length 1/2/0: trig pulses spaced 6 and 10 cycles apart, step_addr 0->1->2, done after the final 4-cycle step.
REQ-037 Entry1 with rest=1: no trig during step 1, mute=1 for its full duration, step timing unchanged.
REQ-038 stop asserted mid-HOLD on a length=7 note: IDLE next edge, mute=1, no done; start and stop asserted together from IDLE: stays IDLE.
REQ-039 Overwrite the current entry's pitch during HOLD: pitch unchanged until the next TRIG of that address.
REQ-040 With NOTE_SEQ_LOOP_EN and last_addr=1: the step_addr sequence is 0,1,0,1..., done stays 0; rst asserted mid-HOLD clears all outputs asynchronously to REQ-030 values.

Source files
------------

// File: rtl/note_sequencer_pkg.sv
// note_sequencer_pkg
// Shared definitions for the note sequencer slice:
//   - bit positions of the fields inside a 16-bit pattern entry
//   - FSM state encoding (IDLE=0, TRIG=1, HOLD=2)
//   - duration counter width and the helper that computes a step's hold count
package note_sequencer_pkg;

  localparam int unsigned ENTRY_W  = 16;
  localparam int unsigned REST_BIT = 15;
  localparam int unsigned LEN_MSB  = 14;
  localparam int unsigned LEN_LSB  = 12;
  localparam int unsigned DEC_MSB  = 11;
  localparam int unsigned DEC_LSB  = 10;
  localparam int unsigned ATK_MSB  = 9;
  localparam int unsigned ATK_LSB  = 8;
  localparam int unsigned PIT_MSB  = 7;
  localparam int unsigned PIT_LSB  = 0;

  // 2**(7+1) = 256 is the largest load, so 9 bits never overflow
  localparam int unsigned DUR_W = 9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TRIG = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef struct packed {
    logic       rest;
    logic [2:0] length;
    logic [1:0] decay;
    logic [1:0] attack;
    logic [7:0] pitch;
  } note_entry_t;

  function automatic note_entry_t entry_unpack(input logic [ENTRY_W-1:0] w);
    note_entry_t e;
    e.rest   = w[REST_BIT];
    e.length = w[LEN_MSB:LEN_LSB];
    e.decay  = w[DEC_MSB:DEC_LSB];
    e.attack = w[ATK_MSB:ATK_LSB];
    e.pitch  = w[PIT_MSB:PIT_LSB];
    return e;
  endfunction

  // Hold count 2**(len+1); shifting 2 by len avoids the 3-bit len+1 wrap at len=7
  function automatic logic [DUR_W-1:0] dur_load(input logic [2:0] len);
    logic [DUR_W-1:0] two;
    two = 9'd2;
    return two << len;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if
// Bundles the pattern write port, playback controls and the note outputs.
//   master : pattern writer / controller (drives wr_*, start, stop, last_addr)
//   slave  : note_sequencer (drives attack, decay, length, pitch, trig, mute,
//            playing, step_addr, done)
interface note_sequencer_if
  import note_sequencer_pkg::*;
#(
  parameter int AW = 4
);
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [ENTRY_W-1:0] wr_data;
  logic               start;
  logic               stop;
  logic [AW-1:0]      last_addr;

  logic [1:0]         attack;
  logic [1:0]         decay;
  logic [2:0]         length;
  logic [7:0]         pitch;
  logic               trig;
  logic               mute;
  logic               playing;
  logic [AW-1:0]      step_addr;
  logic               done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, last_addr,
    input  attack, decay, length, pitch, trig, mute, playing, step_addr, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, last_addr,
    output attack, decay, length, pitch, trig, mute, playing, step_addr, done
  );
endinterface

// File: rtl/note_pattern_ram.sv
// note_pattern_ram
// DEPTH x 16 pattern storage, one synchronous write port, one asynchronous
// read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module note_pattern_ram
  import note_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Pattern write
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer
// Steps through a pattern of note entries and presents the current note's
// parameters to the envelope / waveform stages.
//   note_clk : clock, all state on rising edge
//   rst      : asynchronous active-high reset
//   bus      : note_sequencer_if.slave (pattern write, start/stop, last_addr,
//              note outputs, trig, mute, playing, step_addr, done)
// Configuration macro: NOTE_SEQ_LOOP_EN -- when defined the pattern loops back
// to address 0 after last_addr instead of finishing with a done pulse.
// DEPTH must equal 2**AW.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            note_clk,
  input  logic            rst,
  note_sequencer_if.slave bus
);

  logic [1:0]         state_q,     state_d;
  logic [AW-1:0]      step_addr_q, step_addr_d;
  logic [DUR_W-1:0]   cnt_q,       cnt_d;
  logic [1:0]         attack_q,    attack_d;
  logic [1:0]         decay_q,     decay_d;
  logic [2:0]         length_q,    length_d;
  logic [7:0]         pitch_q,     pitch_d;
  logic               trig_q,      trig_d;
  logic               mute_q,      mute_d;
  logic               playing_q,   playing_d;
  logic               done_q,      done_d;

  logic               load_s;
  logic [ENTRY_W-1:0] rd_word_s;
  note_entry_t        rd_entry_s;

  // Read the entry for the step being entered, so the note registers change
  // only on the edge into TRIG; writes during HOLD cannot disturb them.
  note_pattern_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (note_clk),
    .we    (bus.wr_en),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (step_addr_d),
    .rdata (rd_word_s)
  );

  assign rd_entry_s = entry_unpack(rd_word_s);

  // Next-state and output-register logic
  always_comb begin
    state_d     = state_q;
    step_addr_d = step_addr_q;
    cnt_d       = cnt_q;
    attack_d    = attack_q;
    decay_d     = decay_q;
    length_d    = length_q;
    pitch_d     = pitch_q;
    trig_d      = 1'b0;
    done_d      = 1'b0;
    mute_d      = mute_q;
    load_s      = 1'b0;

    if (bus.stop) begin
      state_d = ST_IDLE;
      cnt_d   = {DUR_W{1'b0}};
      mute_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d     = ST_TRIG;
            step_addr_d = {AW{1'b0}};
            load_s      = 1'b1;
          end else begin
            mute_d = 1'b1;
          end
        end
        ST_TRIG: begin
          cnt_d   = dur_load(length_q);
          state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (cnt_q == 9'd0) begin
            // != rather than < so a step beyond last_addr keeps counting and wraps
            if (step_addr_q != bus.last_addr) begin
              step_addr_d = step_addr_q + {{(AW-1){1'b0}}, 1'b1};
              state_d     = ST_TRIG;
              load_s      = 1'b1;
            end else begin
`ifdef NOTE_SEQ_LOOP_EN
              step_addr_d = {AW{1'b0}};
              state_d     = ST_TRIG;
              load_s      = 1'b1;
`else
              state_d = ST_IDLE;
              done_d  = 1'b1;
              mute_d  = 1'b1;
`endif
            end
          end else begin
            cnt_d = cnt_q - 9'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          mute_d  = 1'b1;
        end
      endcase
    end

    if (load_s) begin
      attack_d = rd_entry_s.attack;
      decay_d  = rd_entry_s.decay;
      length_d = rd_entry_s.length;
      pitch_d  = rd_entry_s.pitch;
      trig_d   = ~rd_entry_s.rest;
      mute_d   = rd_entry_s.rest;
    end else begin
      attack_d = attack_d;
      pitch_d  = pitch_d;
    end

    playing_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge note_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_addr_q <= {AW{1'b0}};
      cnt_q       <= {DUR_W{1'b0}};
      attack_q    <= 2'd0;
      decay_q     <= 2'd0;
      length_q    <= 3'd0;
      pitch_q     <= 8'd0;
      trig_q      <= 1'b0;
      mute_q      <= 1'b1;
      playing_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_addr_q <= step_addr_d;
      cnt_q       <= cnt_d;
      attack_q    <= attack_d;
      decay_q     <= decay_d;
      length_q    <= length_d;
      pitch_q     <= pitch_d;
      trig_q      <= trig_d;
      mute_q      <= mute_d;
      playing_q   <= playing_d;
      done_q      <= done_d;
    end
  end

  assign bus.attack    = attack_q;
  assign bus.decay     = decay_q;
  assign bus.length    = length_q;
  assign bus.pitch     = pitch_q;
  assign bus.trig      = trig_q;
  assign bus.mute      = mute_q;
  assign bus.playing   = playing_q;
  assign bus.step_addr = step_addr_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer
// Directed bench for note_sequencer: outputs sampled on the falling edge,
// inputs driven right after sampling.
module tb_note_sequencer;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  note_sequencer_if #(.AW(AW)) bus ();

  note_sequencer #(.DEPTH(16), .AW(AW)) dut (
    .note_clk (clk),
    .rst      (rst),
    .bus      (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Per-run playback log, cycle 0 is the falling edge where start is raised
  int         trig_c [16];
  logic [3:0] trig_s [16];
  logic [7:0] trig_p [16];
  int         n_trig;
  int         done_c;
  int         n_done;
  bit         mute_log [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic play(input int n);
    n_trig = 0;
    n_done = 0;
    done_c = -1;
    foreach (trig_c[i]) begin
      trig_c[i] = -1;
      trig_s[i] = 4'h0;
      trig_p[i] = 8'h00;
    end
    foreach (mute_log[i]) mute_log[i] = 1'b0;
    bus.start = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (bus.trig === 1'b1) begin
        if (n_trig < 16) begin
          trig_c[n_trig] = c;
          trig_s[n_trig] = bus.step_addr;
          trig_p[n_trig] = bus.pitch;
        end
        n_trig++;
      end
      if (bus.done === 1'b1) begin
        if (n_done == 0) done_c = c;
        n_done++;
      end
      if (c < 64) mute_log[c] = bus.mute;
    end
  endtask

  function automatic int mute_cnt(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += int'(mute_log[i]);
    return s;
  endfunction

  initial begin
    int k;
    rst           = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 4'd0;
    bus.wr_data   = 16'h0000;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.last_addr = 4'd0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_playing", 32'(bus.playing), 32'd0);
    chk("rst_mute",    32'(bus.mute),    32'd1);
    chk("rst_trig",    32'(bus.trig),    32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    chk("rst_step",    32'(bus.step_addr), 32'd0);
    chk("rst_pitch",   32'(bus.pitch),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single note, length 0
    wr(4'd0, 16'h0640);
    bus.last_addr = 4'd0;
    play(8);
    chk("a_ntrig",  32'(n_trig), 32'd1);
    chk("a_trigc",  32'(trig_c[0]), 32'd1);
    chk("a_pitch_at_trig", 32'(trig_p[0]), 32'h40);
    chk("a_donec",  32'(done_c), 32'd5);
    chk("a_ndone",  32'(n_done), 32'd1);
    chk("a_attack", 32'(bus.attack), 32'd2);
    chk("a_decay",  32'(bus.decay),  32'd1);
    chk("a_pitch_hold", 32'(bus.pitch), 32'h40);
    chk("a_playing", 32'(bus.playing), 32'd0);
    chk("a_mute",   32'(bus.mute), 32'd1);

    // Three steps, lengths 1/2/0
    wr(4'd0, 16'h1011);
    wr(4'd1, 16'h2022);
    wr(4'd2, 16'h0033);
    bus.last_addr = 4'd2;
    play(25);
    chk("b_ntrig", 32'(n_trig), 32'd3);
    chk("b_trig0", 32'(trig_c[0]), 32'd1);
    chk("b_trig1", 32'(trig_c[1]), 32'd7);
    chk("b_trig2", 32'(trig_c[2]), 32'd17);
    chk("b_step0", 32'(trig_s[0]), 32'd0);
    chk("b_step1", 32'(trig_s[1]), 32'd1);
    chk("b_step2", 32'(trig_s[2]), 32'd2);
    chk("b_pitch1", 32'(trig_p[1]), 32'h22);
    chk("b_donec", 32'(done_c), 32'd21);
    chk("b_ndone", 32'(n_done), 32'd1);

    // Rest on step 1
    wr(4'd1, 16'hA055);
    play(25);
    chk("c_ntrig", 32'(n_trig), 32'd2);
    chk("c_trig0", 32'(trig_c[0]), 32'd1);
    chk("c_trig1", 32'(trig_c[1]), 32'd17);
    chk("c_step1", 32'(trig_s[1]), 32'd2);
    chk("c_donec", 32'(done_c), 32'd21);
    chk("c_mute_step0", 32'(mute_cnt(1, 6)), 32'd0);
    chk("c_mute_rest",  32'(mute_cnt(7, 16)), 32'd10);
    chk("c_mute_step2", 32'(mute_cnt(17, 20)), 32'd0);

    // Stop in the middle of a length-7 note
    wr(4'd0, 16'h7077);
    bus.last_addr = 4'd0;
    play(20);
    chk("d_trigc", 32'(trig_c[0]), 32'd1);
    chk("d_playing_before", 32'(bus.playing), 32'd1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("d_stop_playing", 32'(bus.playing), 32'd0);
    chk("d_stop_mute",    32'(bus.mute),    32'd1);
    chk("d_stop_trig",    32'(bus.trig),    32'd0);
    chk("d_stop_done",    32'(bus.done),    32'd0);
    k = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.playing === 1'b1) k++;
    end
    chk("d_quiet_after_stop", 32'(k), 32'd0);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    chk("d_both_playing", 32'(bus.playing), 32'd0);
    chk("d_both_trig",    32'(bus.trig),    32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("d_both_playing2", 32'(bus.playing), 32'd0);
    chk("d_pitch_hold",    32'(bus.pitch),   32'h77);

    // Overwrite the playing entry during HOLD
    wr(4'd0, 16'h2010);
    play(3);
    wr(4'd0, 16'h2099);
    @(negedge clk);
    chk("e_pitch_kept", 32'(bus.pitch), 32'h10);
    chk("e_playing",    32'(bus.playing), 32'd1);
    repeat (8) @(negedge clk);
    chk("e_idle", 32'(bus.playing), 32'd0);
    play(4);
    chk("e_ntrig", 32'(n_trig), 32'd1);
    chk("e_new_pitch", 32'(trig_p[0]), 32'h99);
    repeat (10) @(negedge clk);

`ifdef NOTE_SEQ_LOOP_EN
    // Looping over two steps
    wr(4'd0, 16'h0001);
    wr(4'd1, 16'h0002);
    bus.last_addr = 4'd1;
    play(20);
    chk("l_ntrig", 32'(n_trig), 32'd5);
    chk("l_trig4", 32'(trig_c[4]), 32'd17);
    chk("l_step1", 32'(trig_s[1]), 32'd1);
    chk("l_step2", 32'(trig_s[2]), 32'd0);
    chk("l_step3", 32'(trig_s[3]), 32'd1);
    chk("l_ndone", 32'(n_done), 32'd0);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    bus.last_addr = 4'd0;
`endif

    // Asynchronous reset during HOLD
    wr(4'd0, 16'h2B99);
    play(4);
    chk("f_attack_before", 32'(bus.attack), 32'd3);
    chk("f_playing_before", 32'(bus.playing), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("f_rst_pitch",   32'(bus.pitch),   32'd0);
    chk("f_rst_attack",  32'(bus.attack),  32'd0);
    chk("f_rst_decay",   32'(bus.decay),   32'd0);
    chk("f_rst_mute",    32'(bus.mute),    32'd1);
    chk("f_rst_playing", 32'(bus.playing), 32'd0);
    chk("f_rst_step",    32'(bus.step_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
